uart_tx_fifo: RTL and testbench

Parametrised, buffered UART transmitter: the next generation of the team's PicoBlaze-attached UART transmit path. Bytes written through the port-mapped write interface enter a DEPTH-entry FIFO and are serialised back-to-back onto `tx`. Frames are 11 bit-times long with a runtime-selectable 7/8 data bits, optional odd/even parity, and a 16-entry baud table derived from `CLK_HZ`. A status register is readable on `data`, with a sticky overflow flag cleared on read.

---
 rtl/uart_pkg.sv | 66 ++++++
 rtl/sync_fifo.sv | 60 ++++++
 rtl/uart_tx_fifo.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the buffered UART transmitter.
//   - baud rate table and divisor function (clock / rate, truncated)
//   - transmitter FSM state encoding
//   - frame length and status-register bit positions
//   - frame builder (start, data LSB-first, optional parity, stop/pad)
package uart_pkg;

    localparam int unsigned FRAME_BITS = 11;

    // Bit positions inside the status byte {4'b0, busy, overflow, full, empty}
    localparam int unsigned STAT_EMPTY    = 0;
    localparam int unsigned STAT_FULL     = 1;
    localparam int unsigned STAT_OVERFLOW = 2;
    localparam int unsigned STAT_BUSY     = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } tx_state_t;

    function automatic int unsigned baud_rate(input logic [3:0] sel);
        case (sel)
            4'd0:    return 300;
            4'd1:    return 1200;
            4'd2:    return 2400;
            4'd3:    return 4800;
            4'd4:    return 9600;
            4'd5:    return 19200;
            4'd6:    return 38400;
            4'd7:    return 57600;
            4'd8:    return 115200;
            4'd9:    return 230400;
            4'd10:   return 460800;
            default: return 921600;
        endcase
    endfunction

    // Clocks per bit; clamped to 1 so a slow clock never yields a zero period.
    function automatic int unsigned baud_divisor(input int unsigned clk_hz,
                                                 input logic [3:0]  sel);
        int unsigned q;
        q = clk_hz / baud_rate(sel);
        return (q == 0) ? 1 : q;
    endfunction

    // Frame bit 0 goes out first. Unused trailing positions stay 1 so every
    // frame is the same length regardless of data width and parity.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] d,
                                                          input logic       eight,
                                                          input logic       pen,
                                                          input logic       ohel);
        logic [FRAME_BITS-1:0] f;
        f    = '1;
        f[0] = 1'b0;
        if (eight) begin
            f[8:1] = d;
            if (pen) f[9] = (^d) ^ ohel;
        end else begin
            f[7:1] = d[6:0];
            if (pen) f[8] = (^d[6:0]) ^ ohel;
        end
        return f;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered occupancy count.
//   clk, reset     : clock, synchronous active-high reset (pointers/count)
//   push, wdata    : write request and data; accepted when not full, or when
//                    a pop happens in the same cycle
//   pop, rdata     : read request and head-of-queue data (combinational)
//   full, empty    : derived from count, so they move on the same edge as
//                    the push/pop that changes them
//   count          : occupancy, 0..DEPTH
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO still lands when the head leaves this cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter on a port-mapped bus.
//   clk, reset     : clock, synchronous active-high reset
//   eight          : 1 = 8 data bits, 0 = 7 data bits
//   pen, ohel      : parity enable, parity sense (1 = odd)
//   baud           : baud-rate select (0..15)
//   write_strobe   : with port_id == TX_PORT pushes out_port into the FIFO
//   read_strobe    : with port_id == STAT_PORT clears the overflow flag
//   port_id        : port address
//   out_port       : write data
//   tx             : serial output, idle high
//   data           : status {4'b0, busy, overflow, full, empty}
//   tx_done        : one-cycle pulse after the last bit-time of each frame
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned DEPTH     = 8,
    parameter logic [15:0] TX_PORT   = 16'h0000,
    parameter logic [15:0] STAT_PORT = 16'h0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        eight,
    input  logic        pen,
    input  logic        ohel,
    input  logic [3:0]  baud,
    input  logic        write_strobe,
    input  logic        read_strobe,
    input  logic [15:0] port_id,
    input  logic [7:0]  out_port,
    output logic        tx,
    output logic [7:0]  data,
    output logic        tx_done
);

    localparam int unsigned DIV_MAX = baud_divisor(CLK_HZ, 4'd0);
    localparam int unsigned DIV_W   = (DIV_MAX < 2) ? 1 : $clog2(DIV_MAX + 1);
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;

    tx_state_t             state;
    logic                  busy;
    logic                  overflow;
    logic                  push_req;
    logic                  stat_rd;
    logic                  pop_req;

    logic [7:0]            fifo_rdata;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;

    logic [7:0]            byte_lat;
    logic                  eight_lat;
    logic                  pen_lat;
    logic                  ohel_lat;
    logic [DIV_W-1:0]      div_lat;
    logic [DIV_W-1:0]      baud_cnt;
    logic [3:0]            bit_cnt;
    logic [FRAME_BITS-1:0] frame_cur;
    logic [DIV_W-1:0]      div_table [16];

    // Divisors are elaboration-time constants; baud only selects among them.
    for (genvar g = 0; g < 16; g++) begin : g_div
        localparam logic [DIV_W-1:0] DIV = DIV_W'(baud_divisor(CLK_HZ, 4'(g)));
        assign div_table[g] = DIV;
    end

    assign push_req = write_strobe && (port_id == TX_PORT);
    assign stat_rd  = read_strobe  && (port_id == STAT_PORT);
    assign pop_req  = (state == LOAD);
    assign busy     = (state != IDLE);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .wdata (out_port),
        .pop   (pop_req),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assert property (@(posedge clk) disable iff (reset) fifo_count <= CNT_W'(DEPTH));

    // The frame is held as its latched byte plus configuration and rebuilt
    // combinationally; this is equivalent to latching the 11 frame bits.
    always_comb begin
        frame_cur = build_frame(byte_lat, eight_lat, pen_lat, ohel_lat);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tx        <= 1'b1;
            tx_done   <= 1'b0;
            byte_lat  <= '0;
            eight_lat <= 1'b0;
            pen_lat   <= 1'b0;
            ohel_lat  <= 1'b0;
            div_lat   <= '0;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (!fifo_empty) state <= LOAD;
                end
                LOAD: begin
                    byte_lat  <= fifo_rdata;
                    eight_lat <= eight;
                    pen_lat   <= pen;
                    ohel_lat  <= ohel;
                    div_lat   <= div_table[baud];
                    baud_cnt  <= '0;
                    bit_cnt   <= '0;
                    tx        <= 1'b0;   // start bit
                    state     <= SHIFT;
                end
                SHIFT: begin
                    if (baud_cnt == div_lat - DIV_W'(1)) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 4'(FRAME_BITS - 1)) begin
                            tx      <= 1'b1;
                            tx_done <= 1'b1;
                            state   <= fifo_empty ? IDLE : LOAD;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                            tx      <= frame_cur[bit_cnt + 4'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + DIV_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

    // A push dropped on a full FIFO takes priority over a status-read clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (push_req && fifo_full && !pop_req) begin
            overflow <= 1'b1;
        end else if (stat_rd) begin
            overflow <= 1'b0;
        end
    end

    always_comb begin
        data                = '0;
        data[STAT_BUSY]     = busy;
        data[STAT_OVERFLOW] = overflow;
        data[STAT_FULL]     = fifo_full;
        data[STAT_EMPTY]    = fifo_empty;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo at 50 MHz, DEPTH 8.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_tx_fifo;

    localparam int unsigned CLK_HZ    = 50_000_000;
    localparam int unsigned DEPTH     = 8;
    localparam logic [15:0] TX_PORT   = 16'h0000;
    localparam logic [15:0] STAT_PORT = 16'h0001;
    localparam int unsigned N_FAST    = 54;   // 50e6 / 921600

    logic        clk = 1'b0;
    logic        reset;
    logic        eight;
    logic        pen;
    logic        ohel;
    logic [3:0]  baud;
    logic        write_strobe;
    logic        read_strobe;
    logic [15:0] port_id;
    logic [7:0]  out_port;
    logic        tx;
    logic [7:0]  data;
    logic        tx_done;

    int unsigned vectors = 0;
    int unsigned errors  = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .CLK_HZ    (CLK_HZ),
        .DEPTH     (DEPTH),
        .TX_PORT   (TX_PORT),
        .STAT_PORT (STAT_PORT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .eight        (eight),
        .pen          (pen),
        .ohel         (ohel),
        .baud         (baud),
        .write_strobe (write_strobe),
        .read_strobe  (read_strobe),
        .port_id      (port_id),
        .out_port     (out_port),
        .tx           (tx),
        .data         (data),
        .tx_done      (tx_done)
    );

    // Called on a falling edge; returns one falling edge later with the
    // push captured on the rising edge in between.
    task automatic push_byte(input logic [7:0] b);
        write_strobe = 1'b1;
        port_id      = TX_PORT;
        out_port     = b;
        @(negedge clk);
        write_strobe = 1'b0;
    endtask

    // Entered on the falling edge of the LOAD cycle. Checks every clock of
    // all 11 bit-times, then the tx_done pulse that follows. With scramble
    // set, configuration is altered right after LOAD to show it is ignored.
    task automatic check_frame(input string name, input logic [10:0] f,
                               input int unsigned n, input bit scramble);
        int unsigned bad;
        bit          early_done;
        early_done = 1'b0;
        for (int unsigned b = 0; b < 11; b++) begin
            bad = 0;
            for (int unsigned c = 0; c < n; c++) begin
                @(negedge clk);
                write_strobe = 1'b0;
                read_strobe  = 1'b0;
                if (scramble && b == 0 && c == 0) begin
                    eight = ~eight;
                    pen   = ~pen;
                    ohel  = ~ohel;
                    baud  = 4'd0;
                end
                if (tx !== f[b]) bad++;
                if (tx_done !== 1'b0) early_done = 1'b1;
            end
            vectors++;
            if (bad != 0) begin
                errors++;
                $display("FAIL %s bit%0d: tx wrong on %0d of %0d clocks, expected %b",
                         name, b, bad, n, f[b]);
            end
        end
        vectors++;
        if (early_done) begin
            errors++;
            $display("FAIL %s tx_done_early: tx_done seen inside frame, expected 0", name);
        end
        @(negedge clk);
        write_strobe = 1'b0;
        vectors++;
        if (tx_done !== 1'b1 || tx !== 1'b1) begin
            errors++;
            $display("FAIL %s end: tx_done=%b tx=%b, expected tx_done=1 tx=1",
                     name, tx_done, tx);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (tx !== 1'b1 || tx_done !== 1'b0 || data !== 8'h01) begin
            errors++;
            $display("FAIL reset_state: tx=%b tx_done=%b data=%h, expected 1 0 01",
                     tx, tx_done, data);
        end
        reset = 1'b0;
        @(negedge clk);
        // a write to the status port must not enter the FIFO
        write_strobe = 1'b1;
        port_id      = STAT_PORT;
        out_port     = 8'h99;
        @(negedge clk);
        write_strobe = 1'b0;
        port_id      = TX_PORT;
        repeat (2) @(negedge clk);
        vectors++;
        if (data !== 8'h01 || tx !== 1'b1) begin
            errors++;
            $display("FAIL wrong_port_write: data=%h tx=%b, expected 01 1", data, tx);
        end
    endtask

    task automatic test_seven_bit();
        eight = 1'b0; pen = 1'b0; ohel = 1'b0; baud = 4'd11;
        push_byte(8'hAA);
        vectors++;
        if (tx !== 1'b1 || data !== 8'h00) begin
            errors++;
            $display("FAIL t7_after_push: tx=%b data=%h, expected 1 00", tx, data);
        end
        @(negedge clk);
        vectors++;
        if (tx !== 1'b1 || data !== 8'h08) begin
            errors++;
            $display("FAIL t7_load: tx=%b data=%h, expected 1 08", tx, data);
        end
        check_frame("t7_AA", 11'h754, N_FAST, 1'b0);
        vectors++;
        if (data !== 8'h01) begin
            errors++;
            $display("FAIL t7_idle: data=%h, expected 01", data);
        end
        @(negedge clk);
        vectors++;
        if (tx_done !== 1'b0) begin
            errors++;
            $display("FAIL t7_done_width: tx_done=%b, expected 0", tx_done);
        end
    endtask

    task automatic test_parity();
        eight = 1'b1; pen = 1'b1; ohel = 1'b0; baud = 4'd11;
        push_byte(8'hAA);
        @(negedge clk);
        check_frame("even_AA", 11'h554, N_FAST, 1'b0);
        eight = 1'b1; pen = 1'b1; ohel = 1'b1; baud = 4'd11;
        push_byte(8'hAA);
        @(negedge clk);
        check_frame("odd_AA_scrambled", 11'h754, N_FAST, 1'b1);
        // 7-bit even parity: bit 7 of the byte must not affect data or parity
        eight = 1'b0; pen = 1'b1; ohel = 1'b0; baud = 4'd11;
        push_byte(8'hD5);
        @(negedge clk);
        check_frame("seven_even_D5", 11'h6AA, N_FAST, 1'b0);
    endtask

    task automatic test_back_to_back();
        eight = 1'b1; pen = 1'b0; ohel = 1'b0; baud = 4'd11;
        push_byte(8'h55);
        push_byte(8'h0F);
        check_frame("b2b_55", 11'h6AA, N_FAST, 1'b0);
        check_frame("b2b_0F", 11'h61E, N_FAST, 1'b0);
        vectors++;
        if (data !== 8'h01) begin
            errors++;
            $display("FAIL b2b_idle: data=%h, expected 01", data);
        end
    endtask

    task automatic test_overflow();
        eight = 1'b1; pen = 1'b0; ohel = 1'b0; baud = 4'd0;
        for (int unsigned i = 0; i < DEPTH + 2; i++) begin
            write_strobe = 1'b1;
            port_id      = TX_PORT;
            out_port     = 8'(i);
            @(negedge clk);
        end
        write_strobe = 1'b0;
        vectors++;
        if (data !== 8'h0E) begin
            errors++;
            $display("FAIL ovf_set: data=%h, expected 0e", data);
        end
        read_strobe = 1'b1;
        port_id     = TX_PORT;
        @(negedge clk);
        read_strobe = 1'b0;
        vectors++;
        if (data !== 8'h0E) begin
            errors++;
            $display("FAIL ovf_wrong_port_read: data=%h, expected 0e", data);
        end
        read_strobe = 1'b1;
        port_id     = STAT_PORT;
        @(negedge clk);
        read_strobe = 1'b0;
        vectors++;
        if (data !== 8'h0A) begin
            errors++;
            $display("FAIL ovf_clear: data=%h, expected 0a", data);
        end
        @(negedge clk);
        vectors++;
        if (data !== 8'h0A) begin
            errors++;
            $display("FAIL ovf_stays_clear: data=%h, expected 0a", data);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if (data !== 8'h01 || tx !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flush: data=%h tx=%b, expected 01 1", data, tx);
        end
        baud = 4'd11;
    endtask

    task automatic test_reset_mid_frame();
        int unsigned bad;
        eight = 1'b1; pen = 1'b0; ohel = 1'b0; baud = 4'd11;
        push_byte(8'h35);
        @(negedge clk);
        repeat (4 * N_FAST + 27) @(negedge clk);
        vectors++;
        if (tx !== 1'b0) begin
            errors++;
            $display("FAIL rst_pre: tx=%b in bit 4 of 35, expected 0", tx);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if (tx !== 1'b1 || data !== 8'h01) begin
            errors++;
            $display("FAIL rst_mid: tx=%b data=%h, expected 1 01", tx, data);
        end
        bad = 0;
        for (int unsigned c = 0; c < 3 * N_FAST; c++) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_done !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rst_quiet: %0d clocks with tx!=1 or tx_done!=0, expected 0", bad);
        end
        push_byte(8'hC3);
        @(negedge clk);
        check_frame("rst_after_C3", 11'h786, N_FAST, 1'b0);
    endtask

    task automatic test_fill_wrap();
        logic [7:0]  bytes [DEPTH + 2];
        int unsigned w;
        eight = 1'b1; pen = 1'b0; ohel = 1'b0; baud = 4'd11;
        for (int unsigned i = 0; i < DEPTH + 2; i++) bytes[i] = 8'(i * 29 + 49);
        for (int unsigned i = 0; i < DEPTH + 1; i++) begin
            write_strobe = 1'b1;
            port_id      = TX_PORT;
            out_port     = bytes[i];
            @(negedge clk);
        end
        write_strobe = 1'b0;
        vectors++;
        if (data !== 8'h0A) begin
            errors++;
            $display("FAIL fill_full: data=%h, expected 0a", data);
        end
        w = 0;
        while (w < 2000 && tx_done !== 1'b1) begin
            @(negedge clk);
            w++;
        end
        vectors++;
        if (tx_done !== 1'b1) begin
            errors++;
            $display("FAIL fill_wait_done: tx_done=%b after %0d clocks, expected 1", tx_done, w);
        end else begin
            // LOAD cycle while full: this push must land alongside the pop
            vectors++;
            if (data !== 8'h0A) begin
                errors++;
                $display("FAIL fill_load_state: data=%h, expected 0a", data);
            end
            write_strobe = 1'b1;
            port_id      = TX_PORT;
            out_port     = bytes[DEPTH + 1];
            for (int unsigned i = 1; i < DEPTH + 2; i++) begin
                check_frame($sformatf("wrap_%0d", i), {2'b11, bytes[i], 1'b0}, N_FAST, 1'b0);
                if (i == 1) begin
                    vectors++;
                    if (data !== 8'h0A) begin
                        errors++;
                        $display("FAIL fill_push_at_load: data=%h, expected 0a", data);
                    end
                end
            end
            vectors++;
            if (data !== 8'h01) begin
                errors++;
                $display("FAIL fill_drained: data=%h, expected 01", data);
            end
        end
    endtask

    initial begin
        reset        = 1'b1;
        eight        = 1'b0;
        pen          = 1'b0;
        ohel         = 1'b0;
        baud         = 4'd11;
        write_strobe = 1'b0;
        read_strobe  = 1'b0;
        port_id      = TX_PORT;
        out_port     = 8'h00;
        test_reset();
        test_seven_bit();
        test_parity();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
        test_fill_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
